// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle sequencer and the single-cycle decoder.
//   state_e    : sequencer state encoding (3 bits, 7 states)
//   OP_*       : 2-bit opcode values
//   is_mem_op  : true for opcodes that make a data-memory access
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [1:0] OP_RTYPE  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer for the sequencer.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart the count (entry into a memory wait state)
//   cnt_en_i   : count this cycle (memory not ready)
//   expired_o  : the current not-ready cycle is the MEM_TIMEOUT-th one in a row;
//                held low when MEM_TIMEOUT is 0
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam int unsigned TW      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] LAST  = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic ENABLED        = (MEM_TIMEOUT != 0);

  // cnt_q holds the number of not-ready cycles already seen before the
  // current cycle, so LAST means "this is the final cycle still allowed".
  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expired_o = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 2-bit-opcode datapath.
//   Inputs : clk, rst_n (async, active-low), en (run enable), op (opcode),
//            zero (ALU zero flag, qualified in the datapath), mem_ready
//   Outputs: PC/IR/regfile/ALU/memory enables, instr_done pulse,
//            retired (instruction counter, wraps), err (sticky memory timeout)
//
// state  | meaning
// IDLE   | stopped, waiting for en
// FETCH  | instruction read from PC, waits for mem_ready
// DECODE | opcode latched into op_q
// EXEC   | ALU op / address calc / branch resolve
// MEM    | data read or write at ALU address, waits for mem_ready
// WB     | register file write
// ERR    | memory timeout, held until reset
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             err
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             end_instr;
  logic             expired;
  logic             wait_state;
  logic             timer_clr;

  // The branch condition is applied by the datapath's PC write logic.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM);
  // Restart the wait count on every fresh entry; MEM -> FETCH (store followed
  // by the next instruction) is an entry too.
  assign timer_clr  = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .cnt_en_i  (wait_state && !mem_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    end_instr = 1'b0;
    case (state_q)
      ST_IDLE:   if (en) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (expired) state_d = ST_ERR;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_RTYPE)     state_d = ST_WB;
        else if (is_mem_op(op_q)) state_d = ST_MEM;
        else                      end_instr = 1'b1;
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) state_d = ST_WB;
          else                 end_instr = 1'b1;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WB:     end_instr = 1'b1;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
    if (end_instr) state_d = en ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_RTYPE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= op;
      if (end_instr) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXEC: begin
        alu_src       = is_mem_op(op_q);
        alu_op        = (op_q == OP_RTYPE);
        pc_write_cond = (op_q == OP_BRANCH);
      end
      ST_MEM: begin
        iord      = 1'b1;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LOAD);
      end
      default: ;
    endcase
  end

  assign instr_done = end_instr;
  assign retired    = retired_q;
  assign err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, zero, mem_ready;
  logic [1:0]    op;
  logic          pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
  logic          alu_src, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, err;
  logic [CW-1:0] retired;
  logic [11:0]   outs;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .retired(retired), .err(err)
  );

  assign outs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                 alu_src, alu_op, reg_dst, mem_to_reg, reg_write, instr_done};

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int n_mr, n_mw, n_iord, n_irw, n_pcw, n_as, n_ao, n_pcc, n_rw, n_rd, n_m2r;
    int ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Per-instruction signature: latency plus how many cycles each enable is high.
  function automatic exp_t model(input int o, input int fw, input int mw, input int ret);
    exp_t e;
    bit is_r, is_ld, is_st, is_br, is_m;
    is_r  = (o == 0);
    is_ld = (o == 1);
    is_st = (o == 2);
    is_br = (o == 3);
    is_m  = is_ld || is_st;
    e.lat    = (is_br ? 3 : (is_ld ? 5 : 4)) + fw + (is_m ? mw : 0);
    e.n_mr   = fw + 1 + (is_ld ? mw + 1 : 0);
    e.n_mw   = is_st ? mw + 1 : 0;
    e.n_iord = is_m ? mw + 1 : 0;
    e.n_irw  = 1;
    e.n_pcw  = 1;
    e.n_as   = is_m ? 1 : 0;
    e.n_ao   = is_r ? 1 : 0;
    e.n_pcc  = is_br ? 1 : 0;
    e.n_rw   = (is_r || is_ld) ? 1 : 0;
    e.n_rd   = is_r ? 1 : 0;
    e.n_m2r  = is_ld ? 1 : 0;
    e.ret    = ret % (1 << CW);
    return e;
  endfunction

  // Monitor: accumulates the signature of each instruction and compares at instr_done.
  bit   mon_en = 0, in_instr = 0, chk_ret = 0;
  int   cyc = 0, exp_ret_v = 0;
  exp_t acc, e_m;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (chk_ret) begin
        check("retired", int'(retired), exp_ret_v);
        chk_ret = 0;
      end
      if (!in_instr && !mem_read) begin
        check("idle_outputs", int'(outs), 0);
        check("idle_err", int'(err), 0);
      end else begin
        if (!in_instr) begin
          in_instr = 1;
          cyc = 0;
          acc = '{default: 0};
        end
        cyc++;
        acc.n_mr   += int'(mem_read);
        acc.n_mw   += int'(mem_write);
        acc.n_iord += int'(iord);
        acc.n_irw  += int'(ir_write);
        acc.n_pcw  += int'(pc_write);
        acc.n_as   += int'(alu_src);
        acc.n_ao   += int'(alu_op);
        acc.n_pcc  += int'(pc_write_cond);
        acc.n_rw   += int'(reg_write);
        acc.n_rd   += int'(reg_dst);
        acc.n_m2r  += int'(mem_to_reg);
        if (instr_done) begin
          in_instr = 0;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e_m = sb_q.pop_front();
            check("latency", cyc, e_m.lat);
            check("mem_read_cycles", acc.n_mr, e_m.n_mr);
            check("mem_write_cycles", acc.n_mw, e_m.n_mw);
            check("iord_cycles", acc.n_iord, e_m.n_iord);
            check("ir_write_cycles", acc.n_irw, e_m.n_irw);
            check("pc_write_cycles", acc.n_pcw, e_m.n_pcw);
            check("alu_src_cycles", acc.n_as, e_m.n_as);
            check("alu_op_cycles", acc.n_ao, e_m.n_ao);
            check("pc_write_cond_cycles", acc.n_pcc, e_m.n_pcc);
            check("reg_write_cycles", acc.n_rw, e_m.n_rw);
            check("reg_dst_cycles", acc.n_rd, e_m.n_rd);
            check("mem_to_reg_cycles", acc.n_m2r, e_m.n_m2r);
            exp_ret_v = e_m.ret;
            chk_ret = 1;
          end
        end else if (cyc > 100) begin
          check("instr_cycle_budget", cyc, -1);
          in_instr = 0;
        end
      end
    end
  end

  task automatic drive(input logic e, input logic r, input logic [1:0] o);
    en = e;
    mem_ready = r;
    op = o;
    zero = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_wait();
    int v;
    v = $urandom_range(0, 9);
    if (v < 6) return 0;
    if (v < 9) return $urandom_range(1, 4);
    return TO - 1;
  endfunction

  initial begin
    int o, fw, mw, lat, n;
    bit cont, idle, is_m;
    logic r, e;
    logic [1:0] ov;

    rst_n = 1'b0; en = 1'b0; op = 2'b00; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_held", int'(outs), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    check("reset_retired", int'(retired), 0);
    check("reset_err", int'(err), 0);
    @(posedge clk);
    #1;

    mon_en = 1;
    idle = 1;
    n = 0;
    for (int t = 0; t < 150; t++) begin
      o  = $urandom_range(0, 3);
      fw = pick_wait();
      mw = pick_wait();
      cont = ($urandom_range(0, 3) != 0) && (t != 149);
      is_m = (o == 1) || (o == 2);
      if (idle) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      n++;
      sb_q.push_back(model(o, fw, mw, n));
      lat = model(o, fw, mw, n).lat;
      for (int i = 0; i < lat; i++) begin
        r  = 1'($urandom_range(0, 1));
        ov = 2'($urandom_range(0, 3));
        if (i <= fw)                          r = (i == fw);
        else if (i == fw + 1)                 ov = 2'(o);
        else if (i == fw + 2)                 ;
        else if (is_m && (i <= fw + 3 + mw))  r = (i == fw + 3 + mw);
        e = (i == lat - 1) ? cont : 1'($urandom_range(0, 1));
        drive(e, r, ov);
      end
      idle = !cont;
    end

    for (int k = 0; k < 200 && (sb_q.size() != 0 || in_instr); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    mon_en = 0;

    // Reset in the middle of write-back: enables drop at once, counter clears.
    drive(1'b1, 1'b1, 2'b00);
    drive(1'b1, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 2'b00);
    check("wb_reg_write", int'(reg_write), 1);
    check("wb_reg_dst", int'(reg_dst), 1);
    check("wb_retired_before_reset", int'(retired), 150 % (1 << CW));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_reg_write", int'(reg_write), 0);
    check("async_reset_outputs", int'(outs), 0);
    check("async_reset_retired", int'(retired), 0);
    @(posedge clk);
    #1;
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", int'(outs), 0);

    // Fetch that never completes: error on the 15th not-ready cycle.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= TO; k++) begin
      if (k == 1 || k == TO) begin
        check("timeout_fetch_mem_read", int'(mem_read), 1);
        check("timeout_err_not_yet", int'(err), 0);
      end
      drive(1'b0, 1'b0, 2'b00);
    end
    check("timeout_err_set", int'(err), 1);
    check("timeout_outputs_zero", int'(outs), 0);
    repeat (3) drive(1'b1, 1'b1, 2'b00);
    check("err_sticky", int'(err), 1);
    check("err_outputs_zero", int'(outs), 0);
    rst_n = 1'b0;
    #2;
    check("err_cleared_by_reset", int'(err), 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual timeout required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
